pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. It sits beside the F/D, D/X, X/M and M/W pipeline registers and drives their write enables and bubble-insert (flush) controls. It resolves three hazards: multi-cycle mult/div stalls, taken-branch squashes, and load-use stalls. It also produces the start handshake for the multdiv unit and keeps a saturating stall-cycle counter for performance reads.

## Interface

**Parameters**
- MD_TIMEOUT, 40 — maximum cycles spent in MD_WAIT before a forced release.
- CNT_W, 16 — width of stall_count.

**Ports**
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces state IDLE and clears all counters and flags.
- insn_fd  in  32  instruction currently in F/D (decode stage).
- insn_dx  in  32  instruction currently in D/X (execute stage).
- branch_taken  in  1  X-stage redirect (bne/blt taken, j, jal, jr, bex taken) for insn_dx.
- md_ready  in  1  multdiv result valid. Sampled only in MD_WAIT.
- pc_we  out  1  PC register enable.
- fd_we  out  1  F/D enable.
- dx_we  out  1  D/X enable.
- fd_flush  out  1  load nop (32'h0) into F/D at the next edge.
- dx_flush  out  1  load nop into D/X at the next edge.
- xm_flush  out  1  load nop into X/M at the next edge (xm_we is held at 1).
- md_start  out  1  one-cycle start pulse to multdiv.
- md_busy  out  1  a mult/div is held in D/X.
- md_timeout  out  1  sticky flag: a timeout release has occurred.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation

**Decode fields**
- opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- mult/div: opcode 00000 with aluop 00110 or 00111.
- lw: opcode 01000.

**Registers read by insn_fd**
- rs for opcodes 00000, 00101, 00111, 01000, 00010, 00110.
- rt for opcode 00000.
- rd for opcodes 00111, 00010, 00110, 00100.

**load_use**
- Asserted when insn_dx is lw, its rd ≠ 0, and its rd equals any register read by insn_fd.

**FSM states:** IDLE, MD_WAIT. Outputs are Mealy, decided in priority order:
1. **IDLE, insn_dx is mult/div (md stall).**
   - md_start=1, md_busy=1.
   - pc_we=fd_we=dx_we=0, xm_flush=1.
   - Next edge: go to MD_WAIT, wait counter cleared to 0.
2. **MD_WAIT, md_ready=0 and counter < MD_TIMEOUT−1.**
   - Same freeze as case 1, with md_start=0.
   - Counter increments.
3. **MD_WAIT, md_ready=1 or counter = MD_TIMEOUT−1 (release).**
   - All enables 1, no flushes, md_busy=1.
   - Next edge: go to IDLE.
   - If md_ready=0 on this cycle, set md_timeout.
4. **IDLE, branch_taken.**
   - fd_flush=1, dx_flush=1, all enables 1.
5. **IDLE, load_use.**
   - pc_we=fd_we=0, dx_flush=1.
6. **Otherwise:** all enables 1, no flushes, md_start=0, md_busy=0.

**Boundary behaviour**
- branch_taken and load_use in the same cycle: the branch wins and no stall is counted.
- md_ready while in IDLE is ignored.
- After a release, a back-to-back mult/div in D/X the next cycle restarts at case 1.
- stall_count increments every cycle in cases 1, 2 or 5, and saturates at all-ones.
- Asynchronous reset mid-MD_WAIT: state goes to IDLE and the counter clears. If insn_dx is still a mult/div when reset rises, a new md_start is issued.

**Reset values** (with insn_* = 0 and other inputs 0)
- pc_we=fd_we=dx_we=1.
- All flushes 0, md_start=0, md_busy=0, md_timeout=0, stall_count=0.

## Timing
- All outputs are combinational from state and the current inputs. The state, wait counter, md_timeout and stall_count update on the rising clock.
- Load-use penalty: exactly 1 cycle.
- Branch penalty: 2 squashed instructions, no stall cycles.
- Mult/div: if md_ready rises N cycles after the md_start cycle, the instruction occupies D/X for N+1 cycles and contributes N stall counts. It advances to X/M on the edge ending the md_ready cycle.
- Timeout: forced release on the cycle where counter = MD_TIMEOUT−1, i.e. MD_TIMEOUT cycles after md_start.

## Test plan
- **Load-use stall.** insn_dx=32'h40C00000 (lw $3), insn_fd=32'h01065000 (add $4,$3,$5) for one cycle → pc_we=fd_we=0 and dx_flush=1 for that cycle only; stall_count goes 0→1. Repeat with lw $0 (32'h40000000) → no stall.
- **Mult/div handshake.** insn_dx=32'h00443018 (mul), md_ready pulsed 5 cycles after md_start.
  - md_start high for exactly 1 cycle.
  - Freeze with xm_flush=1 for 5 cycles.
  - Release cycle: all enables 1.
  - stall_count=5, md_timeout=0.
- **Timeout.** Same mul with md_ready never asserted → release on cycle 40 after md_start; md_timeout=1 and stays 1 until reset.
- **Branch squash.** branch_taken=1 with a load_use hit also present → fd_flush=dx_flush=1, pc_we=1, stall_count unchanged.
- **Reset mid-operation.** Assert reset 3 cycles into MD_WAIT → outputs return to reset values immediately. After reset rises with the mul still in D/X, md_start pulses again.
- **Counter saturation.** With CNT_W=4, hold a load-use condition for 20 cycles → stall_count stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the five-stage datapath and its hazard/sequencing controller.
// The datapath side (master) supplies the instructions and status and receives the control lines.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      insn_fd;
    logic [31:0]      insn_dx;
    logic             branch_taken;
    logic             md_ready;
    logic             pc_we;
    logic             fd_we;
    logic             dx_we;
    logic             fd_flush;
    logic             dx_flush;
    logic             xm_flush;
    logic             md_start;
    logic             md_busy;
    logic             md_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output insn_fd, insn_dx, branch_taken, md_ready,
        input  pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush,
        input  md_start, md_busy, md_timeout, stall_count
    );

    modport slave (
        input  insn_fd, insn_dx, branch_taken, md_ready,
        output pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush,
        output md_start, md_busy, md_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard controller for the five-stage pipeline: mult/div freeze, branch squash, load-use stall,
// multdiv start handshake and a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    pipeline_ctrl_if.slave    bus
);
    localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t              state_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                md_timeout_r;
    logic [CNT_W-1:0]    stall_count_r;

    logic [4:0]  fd_opcode_s, fd_rd_s, fd_rs_s, fd_rt_s;
    logic [4:0]  dx_opcode_s, dx_rd_s, dx_aluop_s;
    logic        fd_reads_rs_s, fd_reads_rt_s, fd_reads_rd_s;
    logic        dx_is_md_s, dx_is_lw_s, load_use_s, wait_last_s;
    logic        pc_we_s, fd_we_s, dx_we_s, fd_flush_s, dx_flush_s, xm_flush_s;
    logic        md_start_s, md_busy_s, stall_s, release_s;

    assign fd_opcode_s = bus.insn_fd[31:27];
    assign fd_rd_s     = bus.insn_fd[26:22];
    assign fd_rs_s     = bus.insn_fd[21:17];
    assign fd_rt_s     = bus.insn_fd[16:12];
    assign dx_opcode_s = bus.insn_dx[31:27];
    assign dx_rd_s     = bus.insn_dx[26:22];
    assign dx_aluop_s  = bus.insn_dx[6:2];

    assign fd_reads_rs_s = (fd_opcode_s == 5'b00000) || (fd_opcode_s == 5'b00101) ||
                           (fd_opcode_s == 5'b00111) || (fd_opcode_s == 5'b01000) ||
                           (fd_opcode_s == 5'b00010) || (fd_opcode_s == 5'b00110);
    assign fd_reads_rt_s = (fd_opcode_s == 5'b00000);
    assign fd_reads_rd_s = (fd_opcode_s == 5'b00111) || (fd_opcode_s == 5'b00010) ||
                           (fd_opcode_s == 5'b00110) || (fd_opcode_s == 5'b00100);

    assign dx_is_md_s = (dx_opcode_s == 5'b00000) &&
                        ((dx_aluop_s == 5'b00110) || (dx_aluop_s == 5'b00111));
    assign dx_is_lw_s = (dx_opcode_s == 5'b01000);

    // A load writing $0 never creates a dependency.
    assign load_use_s = dx_is_lw_s && (dx_rd_s != 5'd0) &&
                        ((fd_reads_rs_s && (fd_rs_s == dx_rd_s)) ||
                         (fd_reads_rt_s && (fd_rt_s == dx_rd_s)) ||
                         (fd_reads_rd_s && (fd_rd_s == dx_rd_s)));

    assign wait_last_s = (wait_cnt_r == WAIT_W'(MD_TIMEOUT - 1));

    // Mealy control decode in hazard priority order; held at idle values while in reset.
    always_comb begin
        pc_we_s    = 1'b1;
        fd_we_s    = 1'b1;
        dx_we_s    = 1'b1;
        fd_flush_s = 1'b0;
        dx_flush_s = 1'b0;
        xm_flush_s = 1'b0;
        md_start_s = 1'b0;
        md_busy_s  = 1'b0;
        stall_s    = 1'b0;
        release_s  = 1'b0;
        if (reset) begin
            case (state_r)
                IDLE: begin
                    if (dx_is_md_s) begin
                        {pc_we_s, fd_we_s, dx_we_s} = 3'b000;
                        xm_flush_s = 1'b1;
                        md_start_s = 1'b1;
                        md_busy_s  = 1'b1;
                        stall_s    = 1'b1;
                    end else if (bus.branch_taken) begin
                        fd_flush_s = 1'b1;
                        dx_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_we_s    = 1'b0;
                        fd_we_s    = 1'b0;
                        dx_flush_s = 1'b1;
                        stall_s    = 1'b1;
                    end else begin
                        md_busy_s = 1'b0;
                    end
                end
                MD_WAIT: begin
                    md_busy_s = 1'b1;
                    if (bus.md_ready || wait_last_s) begin
                        release_s = 1'b1;
                    end else begin
                        {pc_we_s, fd_we_s, dx_we_s} = 3'b000;
                        xm_flush_s = 1'b1;
                        stall_s    = 1'b1;
                    end
                end
                default: begin
                    md_busy_s = 1'b0;
                end
            endcase
        end else begin
            md_busy_s = 1'b0;
        end
    end

    // Sequencing state, multdiv wait counter, sticky timeout flag and stall counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            md_timeout_r  <= 1'b0;
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (dx_is_md_s) begin
                        state_r    <= MD_WAIT;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MD_WAIT: begin
                    if (release_s) begin
                        state_r <= IDLE;
                        if (!bus.md_ready) begin
                            md_timeout_r <= 1'b1;
                        end else begin
                            md_timeout_r <= md_timeout_r;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_W'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign bus.pc_we       = pc_we_s;
    assign bus.fd_we       = fd_we_s;
    assign bus.dx_we       = dx_we_s;
    assign bus.fd_flush    = fd_flush_s;
    assign bus.dx_flush    = dx_flush_s;
    assign bus.xm_flush    = xm_flush_s;
    assign bus.md_start    = md_start_s;
    assign bus.md_busy     = md_busy_s;
    assign bus.md_timeout  = md_timeout_r;
    assign bus.stall_count = stall_count_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: load-use, branch squash, mult/div handshake, timeout,
// reset during MD_WAIT, and stall counter saturation on a narrow-counter instance.
module tb_pipeline_ctrl;
    // Output vector order: {pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush, md_start, md_busy}
    localparam logic [7:0] O_NORM = 8'b111_000_00;
    localparam logic [7:0] O_LU   = 8'b001_010_00;
    localparam logic [7:0] O_BR   = 8'b111_110_00;
    localparam logic [7:0] O_MDS  = 8'b000_001_11;
    localparam logic [7:0] O_MDW  = 8'b000_001_01;
    localparam logic [7:0] O_REL  = 8'b111_000_01;

    localparam logic [31:0] LW3   = 32'h40C0_0000;
    localparam logic [31:0] LW0   = 32'h4000_0000;
    localparam logic [31:0] ADD3  = 32'h0106_5000;
    localparam logic [31:0] ADD12 = 32'h0102_2000;
    localparam logic [31:0] RDR3  = 32'h38C0_0000;
    localparam logic [31:0] MUL   = 32'h0044_3018;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   exp_cnt;

    pipeline_ctrl_if #(.CNT_W(16)) m ();
    pipeline_ctrl_if #(.CNT_W(4))  s ();

    pipeline_ctrl #(.MD_TIMEOUT(40), .CNT_W(16)) dut (.clock(clock), .reset(reset), .bus(m.slave));
    pipeline_ctrl #(.MD_TIMEOUT(40), .CNT_W(4))  dut_sat (.clock(clock), .reset(reset), .bus(s.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] outs();
        return {m.pc_we, m.fd_we, m.dx_we, m.fd_flush, m.dx_flush, m.xm_flush, m.md_start, m.md_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] fd, input logic [31:0] dx, input logic br, input logic rdy);
        m.insn_fd      = fd;
        m.insn_dx      = dx;
        m.branch_taken = br;
        m.md_ready     = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        s.insn_fd = 32'h0; s.insn_dx = 32'h0; s.branch_taken = 1'b0; s.md_ready = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset_outs", 32'(outs()), 32'(O_NORM));
        chk("reset_timeout", 32'(m.md_timeout), 32'd0);
        chk("reset_count", 32'(m.stall_count), 32'd0);
        #10 reset = 1'b1;
        tick();
        chk("idle_outs", 32'(outs()), 32'(O_NORM));

        // Load-use on rs: one stall cycle
        drive(ADD3, LW3, 1'b0, 1'b0);
        chk("lu_outs", 32'(outs()), 32'(O_LU));
        chk("lu_count_before", 32'(m.stall_count), 32'd0);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("lu_release", 32'(outs()), 32'(O_NORM));
        chk("lu_count_after", 32'(m.stall_count), 32'd1);
        drive(ADD3, LW0, 1'b0, 1'b0);
        chk("lw0_no_stall", 32'(outs()), 32'(O_NORM));
        drive(ADD12, LW3, 1'b0, 1'b0);
        chk("lw_no_dep", 32'(outs()), 32'(O_NORM));
        drive(RDR3, LW3, 1'b0, 1'b0);
        chk("lu_rd_read", 32'(outs()), 32'(O_LU));
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("lu_rd_count", 32'(m.stall_count), 32'd2);

        // Branch wins over load-use, no stall counted
        drive(ADD3, LW3, 1'b1, 1'b0);
        chk("br_outs", 32'(outs()), 32'(O_BR));
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b1);
        chk("br_count", 32'(m.stall_count), 32'd2);
        chk("idle_ready_ignored", 32'(outs()), 32'(O_NORM));
        tick();
        chk("idle_ready_count", 32'(m.stall_count), 32'd2);

        // Mult/div with md_ready 5 cycles after md_start
        drive(32'h0, MUL, 1'b0, 1'b0);
        chk("md_start", 32'(outs()), 32'(O_MDS));
        tick();
        for (int k = 1; k < 5; k++) begin
            chk("md_wait", 32'(outs()), 32'(O_MDW));
            tick();
        end
        drive(32'h0, MUL, 1'b0, 1'b1);
        chk("md_release", 32'(outs()), 32'(O_REL));
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("md_after", 32'(outs()), 32'(O_NORM));
        chk("md_count", 32'(m.stall_count), 32'd7);
        chk("md_no_timeout", 32'(m.md_timeout), 32'd0);

        // Back-to-back mult/div restarts at md_start
        drive(32'h0, MUL, 1'b0, 1'b0);
        tick();
        drive(32'h0, MUL, 1'b0, 1'b1);
        chk("b2b_rel1", 32'(outs()), 32'(O_REL));
        tick();
        drive(32'h0, MUL, 1'b0, 1'b0);
        chk("b2b_restart", 32'(outs()), 32'(O_MDS));
        tick();
        drive(32'h0, MUL, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("b2b_count", 32'(m.stall_count), 32'd9);

        // Timeout: md_ready never arrives, release on cycle 40
        drive(32'h0, MUL, 1'b0, 1'b0);
        chk("to_start", 32'(outs()), 32'(O_MDS));
        tick();
        for (int k = 1; k < 40; k++) begin
            chk("to_wait", 32'(outs()), 32'(O_MDW));
            tick();
        end
        chk("to_release", 32'(outs()), 32'(O_REL));
        chk("to_flag_pre", 32'(m.md_timeout), 32'd0);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("to_flag", 32'(m.md_timeout), 32'd1);
        chk("to_count", 32'(m.stall_count), 32'd49);
        tick();
        tick();
        chk("to_sticky", 32'(m.md_timeout), 32'd1);

        // Reset three cycles into MD_WAIT, mul still in D/X
        drive(32'h0, MUL, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk("rst_pre_wait", 32'(outs()), 32'(O_MDW));
        reset = 1'b0;
        #1;
        chk("rst_outs", 32'(outs()), 32'(O_NORM));
        chk("rst_timeout", 32'(m.md_timeout), 32'd0);
        chk("rst_count", 32'(m.stall_count), 32'd0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_restart", 32'(outs()), 32'(O_MDS));
        tick();
        chk("rst_wait", 32'(outs()), 32'(O_MDW));
        drive(32'h0, MUL, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_final_count", 32'(m.stall_count), 32'd1);

        // Saturation on the 4-bit counter instance
        chk("sat_start", 32'(s.stall_count), 32'd0);
        s.insn_fd = ADD3;
        s.insn_dx = LW3;
        #1;
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        chk("sat_count", 32'(s.stall_count), 32'd15);
        chk("sat_still_stall", 32'(s.pc_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
